mag4_sar_ctrl: RTL and testbench
================================

# mag4_sar_ctrl

Successive-approximation search controller that sits on the driving side of the `mag4com` magnitude comparator. The unknown target is wired to comparator input `a`. This block drives the comparator `b` input with trial values and reads the 3-bit relation back. After WIDTH compares and one verify compare, it reports the target value, an exact-match flag and an error flag, using a start/done handshake.

## Interface
Parameters:
- WIDTH, 4, operand width; sets the number of search steps.

Ports:
- clk  in  1  rising-edge clock; the block uses this single clock only.
- rst_n  in  1  reset; synchronous and active-low.
- start  in  1  request a new search; sampled in IDLE and DONE only.
- cmp  in  3  comparator result for target vs. probe: [2]=a>b, [1]=a==b, [0]=a<b; exactly one bit is legal.
- probe  out  WIDTH  registered trial value driven to comparator `b`.
- busy  out  1  high in CMP and VERIFY.
- done  out  1  one-cycle pulse when result, exact and err are valid.
- result  out  WIDTH  search result; held from done until the next accepted start.
- exact  out  1  high when the verify compare returned equal; held like result.
- err  out  1  high when a non-one-hot cmp was seen during the search; held like result.

## Operation
- States: IDLE, CMP, VERIFY, DONE.
- Working registers: acc (WIDTH bits) and bit index k.
- IDLE:
  - probe=0, busy=0.
  - start=1 → CMP with acc=0, k=WIDTH-1, probe=1<<(WIDTH-1).
- CMP, bit k:
  - probe=acc|(1<<k).
  - cmp=GT or EQ → set acc[k]. cmp=LT → clear acc[k].
  - cmp illegal (000 or more than one bit set) → clear acc[k] and set err_acc.
  - k>0 → k-1, stay in CMP. k==0 → VERIFY.
- VERIFY:
  - probe=acc.
  - exact_acc = (cmp==EQ). An illegal cmp also sets err_acc.
  - Go to DONE.
- DONE:
  - done=1 for this cycle.
  - result, exact and err load from acc, exact_acc and err_acc.
  - Next state is IDLE, or CMP if start=1 (back-to-back search).
- start in CMP or VERIFY: ignored, no effect.
- Stable target: result equals the target and exact=1 for every value 0..2^WIDTH-1, including 0 and all-ones.
- Target changed mid-search: result is undefined, but exact must be 0 unless the final probe matches the new target.
- Arithmetic: only bitwise OR and bit set/clear, no adders. probe never exceeds 2^WIDTH-1.

## Timing
- Reset values: probe=0, busy=0, done=0, result=0, exact=0, err=0; state=IDLE, acc=0.
- Reset mid-search takes effect on the next edge and aborts the search with no done pulse.
- cmp is treated as combinational from probe. It is sampled on the same edge that ends the cycle in which probe is presented.
- Cycle numbering, with start=1 sampled at edge 0:
  - Cycles 1..WIDTH: CMP. For WIDTH=4, probes are MSB-first over cycles 1-4.
  - Cycle WIDTH+1: VERIFY.
  - Cycle WIDTH+2: DONE.
- Latency from the start edge to done high is WIDTH+2 cycles; 6 for WIDTH=4.
- Throughput: one search per WIDTH+2 cycles when start is held high.
- busy is high for exactly WIDTH+1 cycles per search.

## Structure
- Shared package `mag4_pkg`:
  - Constants CMP_GT=3'b100, CMP_EQ=3'b010, CMP_LT=3'b001.
  - State enum {IDLE, CMP, VERIFY, DONE}.
  - Function `cmp_legal` (one-hot check).
- Single flat module with no sub-module.
- The comparator is external; the bench instantiates `mag4com` with `a`=target, `b`=probe, `o`=cmp.

## Test plan
- Target 0101, start pulse → probes 1000, 0100, 0110, 0101 in cycles 1-4, then 0101 in VERIFY. done in cycle 6 with result=0101, exact=1, err=0.
- Targets 0000 and 1111, start held high → back-to-back searches. Results 0000 then 1111, both exact=1, done pulses 6 cycles apart, busy low only in DONE.
- Target 1011, change target to 0011 after cycle 2 → done in cycle 6 with exact=0, err=0.
- cmp forced to 000 during cycle 3 with target 1101 → err=1 at done, result bit 1 cleared (1101 becomes 1101&~0010=1101, so check bit k=1 was not set), exact per verify.
- rst_n low at cycle 3 of a search → next edge: all outputs 0, state IDLE, no done. A later start completes normally.
- start pulsed in cycles 2 and 4 of a running search → ignored: a single done in cycle 6, correct result.

Source files
------------

// File: rtl/mag4_pkg.sv
// Shared constants, state encoding and helpers for the
// mag4 successive-approximation search controller.
package mag4_pkg;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    VERIFY,
    DONE
  } state_e;

  function automatic logic cmp_legal(input logic [2:0] c);
    return (c == CMP_GT) || (c == CMP_EQ) || (c == CMP_LT);
  endfunction

endpackage

// File: rtl/mag4_sar_ctrl.sv
// SAR search controller driving the b side of a mag4com
// comparator; finds the value wired to its a side.
module mag4_sar_ctrl
  import mag4_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       cmp,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             exact,
  output logic             err
);

  localparam logic [WIDTH-1:0] MSB =
    {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] probe_q, probe_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_acc_q, err_acc_d;
  logic             exact_q, exact_d;
  logic             err_q, err_d;

  logic             legal;
  logic             take;
  logic [WIDTH-1:0] acc_n;

  // bit_q is the search index k held one-hot, so the
  // step walks by shifting and no adder is needed
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    bit_d     = bit_q;
    probe_d   = probe_q;
    result_d  = result_q;
    err_acc_d = err_acc_q;
    exact_d   = exact_q;
    err_d     = err_q;

    legal = cmp_legal(cmp);
    take  = legal && ((cmp == CMP_GT) || (cmp == CMP_EQ));
    acc_n = take ? (acc_q | bit_q) : (acc_q & ~bit_q);

    unique case (state_q)
      IDLE, DONE: begin
        probe_d = '0;
        state_d = IDLE;
        if (start) begin
          state_d   = CMP;
          acc_d     = '0;
          bit_d     = MSB;
          probe_d   = MSB;
          err_acc_d = 1'b0;
        end
      end
      CMP: begin
        acc_d = acc_n;
        if (!legal) err_acc_d = 1'b1;
        if (bit_q[0]) begin
          state_d = VERIFY;
          probe_d = acc_n;
        end else begin
          bit_d   = bit_q >> 1;
          probe_d = acc_n | (bit_q >> 1);
        end
      end
      VERIFY: begin
        state_d  = DONE;
        probe_d  = '0;
        result_d = acc_q;
        exact_d  = (cmp == CMP_EQ);
        err_d    = err_acc_q | ~legal;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      bit_q     <= '0;
      probe_q   <= '0;
      result_q  <= '0;
      err_acc_q <= 1'b0;
      exact_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      bit_q     <= bit_d;
      probe_q   <= probe_d;
      result_q  <= result_d;
      err_acc_q <= err_acc_d;
      exact_q   <= exact_d;
      err_q     <= err_d;
    end
  end

  assign probe  = probe_q;
  assign busy   = (state_q == CMP) || (state_q == VERIFY);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign exact  = exact_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mag4_sar_ctrl.sv
// Directed bench for mag4_sar_ctrl with a behavioural
// magnitude comparator closing the loop.
module tb_mag4_sar_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] cmp;
  logic [3:0] probe;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       exact;
  logic       err;

  logic [3:0] target;
  logic       force_en;
  logic [2:0] force_val;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [3:0] tgt;
    logic [3:0] res;
  } vec_t;

  vec_t vt[8];

  mag4_sar_ctrl #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .cmp    (cmp),
    .probe  (probe),
    .busy   (busy),
    .done   (done),
    .result (result),
    .exact  (exact),
    .err    (err)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (force_en)             cmp = force_val;
    else if (target > probe)  cmp = 3'b100;
    else if (target == probe) cmp = 3'b010;
    else                      cmp = 3'b001;
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic run_search(input  logic [3:0] t,
                            output logic [3:0] r,
                            output logic       x,
                            output logic       e,
                            output int         lat);
    target = t;
    lat = 0;
    r = '0; x = 1'b0; e = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (done) begin
        lat = n;
        r = result; x = exact; e = err;
        break;
      end
    end
  endtask

  initial begin
    logic [3:0] r;
    logic       x, e;
    int         lat;
    int         ndone;
    int         first;
    logic [3:0] ep[5];

    rst_n = 1'b0; start = 1'b0; target = '0;
    force_en = 1'b0; force_val = '0;
    repeat (2) @(negedge clk);
    check("rst_probe",  32'(probe),  0);
    check("rst_busy",   32'(busy),   0);
    check("rst_done",   32'(done),   0);
    check("rst_result", 32'(result), 0);
    check("rst_exact",  32'(exact),  0);
    check("rst_err",    32'(err),    0);
    rst_n = 1'b1;

    vt[0] = '{4'h5, 4'h5}; vt[1] = '{4'h0, 4'h0};
    vt[2] = '{4'hF, 4'hF}; vt[3] = '{4'h8, 4'h8};
    vt[4] = '{4'h7, 4'h7}; vt[5] = '{4'hA, 4'hA};
    vt[6] = '{4'h1, 4'h1}; vt[7] = '{4'hE, 4'hE};
    for (int i = 0; i < 8; i++) begin
      run_search(vt[i].tgt, r, x, e, lat);
      check("tbl_result", 32'(r), 32'(vt[i].res));
      check("tbl_exact",  32'(x), 1);
      check("tbl_err",    32'(e), 0);
      check("tbl_lat",    32'(lat), 6);
    end

    // probe trace for target 0101
    ep[0] = 4'h8; ep[1] = 4'h4; ep[2] = 4'h6;
    ep[3] = 4'h5; ep[4] = 4'h5;
    target = 4'h5;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n <= 5) begin
        check("seq_probe", 32'(probe), 32'(ep[n-1]));
        check("seq_busy",  32'(busy),  1);
        check("seq_done",  32'(done),  0);
      end else begin
        check("seq_done6",  32'(done),   1);
        check("seq_busy6",  32'(busy),   0);
        check("seq_result", 32'(result), 5);
        check("seq_exact",  32'(exact),  1);
        check("seq_err",    32'(err),    0);
      end
    end

    // back-to-back with start held high
    @(negedge clk);
    target = 4'h0;
    start = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      check("b2b_done", 32'(done),
            32'((n == 6) || (n == 12)));
      check("b2b_busy", 32'(busy),
            32'(!((n == 6) || (n == 12))));
      if (n == 6) begin
        check("b2b_res0",   32'(result), 0);
        check("b2b_exact0", 32'(exact),  1);
        target = 4'hF;
      end
      if (n == 12) begin
        check("b2b_res1",   32'(result), 15);
        check("b2b_exact1", 32'(exact),  1);
        start = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_idle", 32'(busy), 0);

    // target changes mid-search
    target = 4'hB;
    @(negedge clk);
    start = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 3) target = 4'h3;
      if (done) begin
        lat = n; x = exact; e = err;
        break;
      end
    end
    check("chg_lat",   32'(lat), 6);
    check("chg_exact", 32'(x),   0);
    check("chg_err",   32'(e),   0);

    // illegal cmp in cycle 3
    target = 4'hD;
    @(negedge clk);
    start = 1'b1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 3) begin
        check("ill_probe3", 32'(probe), 14);
        force_en = 1'b1; force_val = 3'b000;
      end
      if (n == 4) force_en = 1'b0;
      if (done) begin
        lat = n; r = result; x = exact; e = err;
        break;
      end
    end
    force_en = 1'b0;
    check("ill_lat",    32'(lat),  6);
    check("ill_err",    32'(e),    1);
    check("ill_bit1",   32'(r[1]), 0);
    check("ill_result", 32'(r),    13);
    check("ill_exact",  32'(x),    1);

    // reset in cycle 3 aborts the search
    target = 4'h9;
    @(negedge clk);
    start = 1'b1;
    ndone = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (done) ndone++;
      if (n == 3) rst_n = 1'b0;
      if (n == 4) begin
        check("mrst_probe",  32'(probe),  0);
        check("mrst_busy",   32'(busy),   0);
        check("mrst_done",   32'(done),   0);
        check("mrst_result", 32'(result), 0);
        check("mrst_exact",  32'(exact),  0);
        check("mrst_err",    32'(err),    0);
        rst_n = 1'b1;
      end
    end
    check("mrst_nodone", 32'(ndone), 0);
    run_search(4'h9, r, x, e, lat);
    check("mrst_result2", 32'(r),   9);
    check("mrst_exact2",  32'(x),   1);
    check("mrst_lat2",    32'(lat), 6);

    // start pulses during a search are ignored
    target = 4'h6;
    @(negedge clk);
    start = 1'b1;
    ndone = 0;
    first = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      start = (n == 2) || (n == 4);
      if (done) begin
        ndone++;
        if (first == 0) begin
          first = n;
          r = result;
        end
      end
    end
    start = 1'b0;
    check("ign_count",  32'(ndone), 1);
    check("ign_cycle",  32'(first), 6);
    check("ign_result", 32'(r),     6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
